// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory bus.
// Port 0 = instruction fetch, port 1 = data/DMA. One transaction in flight at a
// time: IDLE -> ISSUE -> (write: IDLE) | (read: WAIT -> RESP -> IDLE).
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1,   // 1..7
    parameter int FIXED_PRIO = 0    // 1: port 0 wins ties
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wrdata0,
    input  logic [DATA_W-1:0] i_wrdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic [DATA_W-1:0] i_mem_rddata
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrdata;
    } req_t;

    state_t            state, state_nxt;
    req_t              req_in [2];
    req_t              req_q;
    logic              win_nxt;
    logic              win_q;
    logic              last_q;   // port that won most recently (round-robin)
    logic [2:0]        cnt_q;    // read wait counter, saturating
    logic [DATA_W-1:0] rdata_q;

    assign req_in[0] = '{we: i_we[0], addr: i_addr0, wrdata: i_wrdata0};
    assign req_in[1] = '{we: i_we[1], addr: i_addr1, wrdata: i_wrdata1};

    // Winner selection: single requester always wins; ties by priority mode.
    always_comb begin
        win_nxt = 1'b0;
        case (i_req)
            2'b01:   win_nxt = 1'b0;
            2'b10:   win_nxt = 1'b1;
            2'b11:   win_nxt = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            default: win_nxt = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|i_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = req_q.we ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt_q == LAT) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, round-robin pointer, wait counter and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
        end else begin
            if (state == S_IDLE && (|i_req)) begin
                // Latched copy is used from here on, even if the request drops.
                req_q <= req_in[win_nxt];
                win_q <= win_nxt;
                if (FIXED_PRIO == 0) last_q <= win_nxt;
            end
            case (state)
                S_ISSUE: cnt_q <= 3'd1;
                S_WAIT: begin
                    if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == LAT)  rdata_q <= i_mem_rddata;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; memory bus is quiet outside ISSUE.
    always_comb begin
        o_gnt        = 2'b00;
        o_rvalid     = 2'b00;
        o_mem_addr   = '0;
        o_mem_wrdata = '0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        case (state)
            S_ISSUE: begin
                o_gnt[win_q] = 1'b1;
                o_mem_addr   = req_q.addr;
                o_mem_wrdata = req_q.wrdata;
                o_mem_rd     = ~req_q.we;
                o_mem_wr     = req_q.we;
            end
            S_RESP:  o_rvalid[win_q] = 1'b1;
            default: ;
        endcase
    end

    assign o_busy  = (state != S_IDLE);
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances cover the parameter
// corners: [0] RD_LATENCY=1 round-robin, [1] RD_LATENCY=1 fixed priority,
// [2] RD_LATENCY=3 round-robin. Each has a small latency-exact memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req [3];
    logic [1:0]  we [3];
    logic [15:0] addr0 [3], addr1 [3], wd0 [3], wd1 [3];
    logic [1:0]  gnt [3], rvalid [3];
    logic [15:0] rdata [3], mem_addr [3], mem_wrdata [3], mem_rddata [3];
    logic        busy [3], mem_rd [3], mem_wr [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1), .FIXED_PRIO(0)) u_rr1 (
        .clk(clk), .reset(reset), .i_req(req[0]), .i_we(we[0]),
        .i_addr0(addr0[0]), .i_addr1(addr1[0]), .i_wrdata0(wd0[0]), .i_wrdata1(wd1[0]),
        .o_gnt(gnt[0]), .o_rvalid(rvalid[0]), .o_rdata(rdata[0]), .o_busy(busy[0]),
        .o_mem_addr(mem_addr[0]), .o_mem_rd(mem_rd[0]), .o_mem_wr(mem_wr[0]),
        .o_mem_wrdata(mem_wrdata[0]), .i_mem_rddata(mem_rddata[0]));

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1), .FIXED_PRIO(1)) u_fp1 (
        .clk(clk), .reset(reset), .i_req(req[1]), .i_we(we[1]),
        .i_addr0(addr0[1]), .i_addr1(addr1[1]), .i_wrdata0(wd0[1]), .i_wrdata1(wd1[1]),
        .o_gnt(gnt[1]), .o_rvalid(rvalid[1]), .o_rdata(rdata[1]), .o_busy(busy[1]),
        .o_mem_addr(mem_addr[1]), .o_mem_rd(mem_rd[1]), .o_mem_wr(mem_wr[1]),
        .o_mem_wrdata(mem_wrdata[1]), .i_mem_rddata(mem_rddata[1]));

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(3), .FIXED_PRIO(0)) u_rr3 (
        .clk(clk), .reset(reset), .i_req(req[2]), .i_we(we[2]),
        .i_addr0(addr0[2]), .i_addr1(addr1[2]), .i_wrdata0(wd0[2]), .i_wrdata1(wd1[2]),
        .o_gnt(gnt[2]), .o_rvalid(rvalid[2]), .o_rdata(rdata[2]), .o_busy(busy[2]),
        .o_mem_addr(mem_addr[2]), .o_mem_rd(mem_rd[2]), .o_mem_wr(mem_wr[2]),
        .o_mem_wrdata(mem_wrdata[2]), .i_mem_rddata(mem_rddata[2]));

    // Memory contents: 0x0010 holds 0xBEEF, everything else is addr ^ 0x5A5A.
    function automatic logic [15:0] model(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // Memory model: data appears exactly RD_LATENCY cycles after the read strobe,
    // zero otherwise, so a mistimed capture shows up as wrong data.
    logic [2:0]  mv [3];
    logic [15:0] ma [3][3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) mv[k] <= 3'b000;
            else       mv[k] <= {mv[k][1:0], mem_rd[k]};
            ma[k][0] <= mem_addr[k];
            ma[k][1] <= ma[k][0];
            ma[k][2] <= ma[k][1];
        end
    end
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_rddata[k] = mv[k][2] ? model(ma[k][2]) : 16'h0000;
            else        mem_rddata[k] = mv[k][0] ? model(ma[k][0]) : 16'h0000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 2'b11; we[k] = 2'b00;
            addr0[k] = 16'h0A0A; addr1[k] = 16'h0B0B; wd0[k] = 16'h1111; wd1[k] = 16'h2222;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if ({gnt[k], rvalid[k], busy[k], mem_rd[k], mem_wr[k]} !== 7'd0) begin
                    n_fail++;
                    $display("FAIL reset_ctrl inst%0d cyc%0d: got gnt=%b rvalid=%b busy=%b rd=%b wr=%b want all 0",
                             k, c, gnt[k], rvalid[k], busy[k], mem_rd[k], mem_wr[k]);
                end
                n_tests++;
                if ({mem_addr[k], mem_wrdata[k], rdata[k]} !== 48'd0) begin
                    n_fail++;
                    $display("FAIL reset_data inst%0d cyc%0d: got addr=%h wrdata=%h rdata=%h want 0",
                             k, c, mem_addr[k], mem_wrdata[k], rdata[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) req[k] = 2'b00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        req[0] = 2'b01; we[0] = 2'b00; addr0[0] = 16'h0010;
        tick();  // ISSUE
        n_tests++;
        if ({gnt[0], mem_rd[0], mem_wr[0], busy[0]} !== 5'b01_1_0_1) begin
            n_fail++;
            $display("FAIL read_issue: got gnt=%b rd=%b wr=%b busy=%b want gnt=01 rd=1 wr=0 busy=1",
                     gnt[0], mem_rd[0], mem_wr[0], busy[0]);
        end
        n_tests++;
        if (mem_addr[0] !== 16'h0010) begin
            n_fail++; $display("FAIL read_addr: got %h want 0010", mem_addr[0]);
        end
        req[0] = 2'b00;
        tick();  // WAIT
        n_tests++;
        if ({gnt[0], rvalid[0], mem_rd[0], mem_addr[0]} !== 21'd0) begin
            n_fail++;
            $display("FAIL read_wait: got gnt=%b rvalid=%b rd=%b addr=%h want 0",
                     gnt[0], rvalid[0], mem_rd[0], mem_addr[0]);
        end
        tick();  // RESP
        n_tests++;
        if (rvalid[0] !== 2'b01 || rdata[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_resp: got rvalid=%b rdata=%h want rvalid=01 rdata=beef", rvalid[0], rdata[0]);
        end
        tick();  // IDLE
        n_tests++;
        if (rvalid[0] !== 2'b00 || busy[0] !== 1'b0 || rdata[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_idle: got rvalid=%b busy=%b rdata=%h want 00 0 beef", rvalid[0], busy[0], rdata[0]);
        end
    endtask

    task automatic test_write();
        req[0] = 2'b10; we[0] = 2'b10; addr1[0] = 16'h0100; wd1[0] = 16'h1234;
        tick();  // ISSUE
        n_tests++;
        if ({gnt[0], mem_wr[0], mem_rd[0]} !== 4'b10_1_0) begin
            n_fail++;
            $display("FAIL write_issue: got gnt=%b wr=%b rd=%b want gnt=10 wr=1 rd=0", gnt[0], mem_wr[0], mem_rd[0]);
        end
        n_tests++;
        if (mem_addr[0] !== 16'h0100 || mem_wrdata[0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_bus: got addr=%h data=%h want 0100 1234", mem_addr[0], mem_wrdata[0]);
        end
        req[0] = 2'b00; we[0] = 2'b00;
        tick();  // back in IDLE
        n_tests++;
        if ({busy[0], mem_wr[0], rvalid[0], gnt[0]} !== 6'd0) begin
            n_fail++;
            $display("FAIL write_idle: got busy=%b wr=%b rvalid=%b gnt=%b want 0", busy[0], mem_wr[0], rvalid[0], gnt[0]);
        end
        tick();
        n_tests++;
        if (rvalid[0] !== 2'b00) begin
            n_fail++; $display("FAIL write_no_rvalid: got %b want 00", rvalid[0]);
        end
    endtask

    // Last winner was port 1 (the write), so port 0 goes first.
    task automatic test_round_robin();
        logic [1:0]  expv;
        logic [15:0] ea;
        int          w;
        req[0] = 2'b11; we[0] = 2'b00; addr0[0] = 16'h0020; addr1[0] = 16'h0030;
        for (int g = 0; g < 4; g++) begin
            expv = (g % 2 == 0) ? 2'b01 : 2'b10;
            ea   = (g % 2 == 0) ? 16'h0020 : 16'h0030;
            w = 0;
            do begin tick(); w++; end while (gnt[0] == 2'b00 && w < 8);
            n_tests++;
            if (gnt[0] !== expv || w != ((g == 0) ? 1 : 2) || mem_addr[0] !== ea) begin
                n_fail++;
                $display("FAIL rr_gnt%0d: got gnt=%b after %0d cyc addr=%h want gnt=%b after %0d addr=%h",
                         g, gnt[0], w, mem_addr[0], expv, (g == 0) ? 1 : 2, ea);
            end
            w = 0;
            do begin tick(); w++; end while (rvalid[0] == 2'b00 && w < 8);
            n_tests++;
            if (rvalid[0] !== expv || w != 2 || rdata[0] !== model(ea)) begin
                n_fail++;
                $display("FAIL rr_rvalid%0d: got rvalid=%b after %0d cyc rdata=%h want %b after 2 rdata=%h",
                         g, rvalid[0], w, rdata[0], expv, model(ea));
            end
        end
        req[0] = 2'b00;
        tick();
    endtask

    task automatic test_fixed_prio();
        int w;
        req[1] = 2'b11; we[1] = 2'b00; addr0[1] = 16'h0070; addr1[1] = 16'h0080;
        for (int g = 0; g < 3; g++) begin
            w = 0;
            do begin tick(); w++; end while (gnt[1] == 2'b00 && w < 8);
            n_tests++;
            if (gnt[1] !== 2'b01 || mem_addr[1] !== 16'h0070) begin
                n_fail++;
                $display("FAIL fp_gnt%0d: got gnt=%b addr=%h want gnt=01 addr=0070", g, gnt[1], mem_addr[1]);
            end
            w = 0;
            do begin tick(); w++; end while (rvalid[1] == 2'b00 && w < 8);
            n_tests++;
            if (rvalid[1] !== 2'b01 || rdata[1] !== model(16'h0070)) begin
                n_fail++;
                $display("FAIL fp_rvalid%0d: got rvalid=%b rdata=%h want 01 %h", g, rvalid[1], rdata[1], model(16'h0070));
            end
        end
        req[1] = 2'b10;  // port 0 drops; port 1 finally gets in
        w = 0;
        do begin tick(); w++; end while (gnt[1] == 2'b00 && w < 8);
        n_tests++;
        if (gnt[1] !== 2'b10 || w != 2 || mem_addr[1] !== 16'h0080) begin
            n_fail++;
            $display("FAIL fp_port1: got gnt=%b after %0d cyc addr=%h want gnt=10 after 2 addr=0080", gnt[1], w, mem_addr[1]);
        end
        w = 0;
        do begin tick(); w++; end while (rvalid[1] == 2'b00 && w < 8);
        n_tests++;
        if (rvalid[1] !== 2'b10 || rdata[1] !== model(16'h0080)) begin
            n_fail++;
            $display("FAIL fp_port1_rvalid: got rvalid=%b rdata=%h want 10 %h", rvalid[1], rdata[1], model(16'h0080));
        end
        req[1] = 2'b00;
        tick();
    endtask

    // Port 0 read in flight (pointer now 0), reset in second WAIT cycle:
    // read is dropped and the pointer returns to favour port 0.
    task automatic test_reset_in_wait();
        int w;
        req[2] = 2'b01; we[2] = 2'b00; addr0[2] = 16'h0040;
        tick();  // ISSUE
        n_tests++;
        if (gnt[2] !== 2'b01) begin
            n_fail++; $display("FAIL rw_first_gnt: got %b want 01", gnt[2]);
        end
        req[2] = 2'b00;
        tick();  // WAIT 1
        tick();  // WAIT 2
        n_tests++;
        if (busy[2] !== 1'b1 || rvalid[2] !== 2'b00) begin
            n_fail++; $display("FAIL rw_in_wait: got busy=%b rvalid=%b want 1 00", busy[2], rvalid[2]);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (busy[2] !== 1'b0 || rvalid[2] !== 2'b00 || gnt[2] !== 2'b00 || rdata[2] !== 16'h0000) begin
                n_fail++;
                $display("FAIL rw_reset%0d: got busy=%b rvalid=%b gnt=%b rdata=%h want 0 00 00 0000",
                         c, busy[2], rvalid[2], gnt[2], rdata[2]);
            end
        end
        reset = 1'b0;
        req[2] = 2'b11; addr0[2] = 16'h0050; addr1[2] = 16'h0060;
        w = 0;
        do begin
            tick(); w++;
            n_tests++;
            if (rvalid[2] !== 2'b00) begin
                n_fail++; $display("FAIL rw_stale_rvalid: got %b want 00", rvalid[2]);
            end
        end while (gnt[2] == 2'b00 && w < 8);
        n_tests++;
        if (gnt[2] !== 2'b01 || w != 1 || mem_addr[2] !== 16'h0050) begin
            n_fail++;
            $display("FAIL rw_after_reset_gnt: got gnt=%b after %0d cyc addr=%h want 01 after 1 addr=0050", gnt[2], w, mem_addr[2]);
        end
        req[2] = 2'b00;
        w = 0;
        do begin tick(); w++; end while (rvalid[2] == 2'b00 && w < 10);
        n_tests++;
        if (rvalid[2] !== 2'b01 || w != 4 || rdata[2] !== model(16'h0050)) begin
            n_fail++;
            $display("FAIL rw_lat3_rvalid: got rvalid=%b after %0d cyc rdata=%h want 01 after 4 rdata=%h",
                     rvalid[2], w, rdata[2], model(16'h0050));
        end
        tick();
        n_tests++;
        if (busy[2] !== 1'b0) begin
            n_fail++; $display("FAIL rw_idle: got busy=%b want 0", busy[2]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_fixed_prio();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
